// File: rtl/sort_batch_checker.sv
// Batch initiator and result checker for the byte insertion sorter: sends DEPTH LFSR words, drains DEPTH words, checks order and sum.
// Optional macro SORT_CHECK_TIMEOUT_EN adds a stall watchdog and the timeout_o port.
module sort_batch_checker #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 10,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
`ifdef SORT_CHECK_TIMEOUT_EN
    output logic                  timeout_o,
`endif
    output logic [DEPTH_LOG2-1:0] err_count_o
);

    localparam int unsigned SUM_W = WIDTH + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_BEAT = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    state_t                 state_r;
    logic [15:0]            lfsr_r;
    logic [DEPTH_LOG2-1:0]  cnt_r;
    logic [SUM_W-1:0]       sum_tx_r;
    logic [SUM_W-1:0]       sum_rx_r;
    logic [WIDTH-1:0]       prev_r;

    logic                   tx_beat_s;
    logic                   rx_beat_s;
    logic                   out_of_order_s;
    logic                   stall_abort_s;
    logic [15:0]            lfsr_nxt_s;
    logic [SUM_W-1:0]       sum_rx_nxt_s;
    logic [DEPTH_LOG2-1:0]  err_nxt_s;

    // Handshake decode and the next-value arithmetic used on a receive beat.
    always_comb begin
        tx_beat_s      = valid_o && ready_i;
        rx_beat_s      = ready_o && valid_i;
        lfsr_nxt_s     = lfsr_step(lfsr_r);
        sum_rx_nxt_s   = sum_rx_r + SUM_W'(data_i);
        out_of_order_s = (cnt_r != '0) && (data_i < prev_r);
        if (out_of_order_s && (err_count_o != '1)) begin
            err_nxt_s = err_count_o + DEPTH_LOG2'(1);
        end else begin
            err_nxt_s = err_count_o;
        end
    end

`ifdef SORT_CHECK_TIMEOUT_EN
    logic [15:0] idle_cnt_r;
    logic        stalled_s;

    // A stall is a SEND/RECV cycle without a handshake; the 65535th in a row aborts.
    always_comb begin
        stalled_s = ((state_r == SEND) && !tx_beat_s) || ((state_r == RECV) && !rx_beat_s);
        if (stalled_s) begin
            stall_abort_s = (idle_cnt_r == 16'hFFFE);
        end else begin
            stall_abort_s = 1'b0;
        end
    end

    // Stall counter and sticky timeout flag, cleared by the next accepted start.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            idle_cnt_r <= 16'd0;
            timeout_o  <= 1'b0;
        end else begin
            if (stall_abort_s) begin
                timeout_o <= 1'b1;
            end else if ((state_r == IDLE) && start_i) begin
                timeout_o <= 1'b0;
            end
            if (stalled_s) begin
                idle_cnt_r <= idle_cnt_r + 16'd1;
            end else begin
                idle_cnt_r <= 16'd0;
            end
        end
    end
`else
    assign stall_abort_s = 1'b0;
`endif

    // Batch sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r     <= IDLE;
            lfsr_r      <= SEED;
            cnt_r       <= '0;
            sum_tx_r    <= '0;
            sum_rx_r    <= '0;
            prev_r      <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            err_count_o <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state_r     <= SEND;
                        cnt_r       <= '0;
                        sum_tx_r    <= '0;
                        sum_rx_r    <= '0;
                        err_count_o <= '0;
                        pass_o      <= 1'b0;
                        valid_o     <= 1'b1;
                        data_o      <= lfsr_r[WIDTH-1:0];
                        busy_o      <= 1'b1;
                    end
                end
                SEND: begin
                    if (stall_abort_s) begin
                        state_r <= DONE;
                        valid_o <= 1'b0;
                        data_o  <= '0;
                        cnt_r   <= '0;
                        done_o  <= 1'b1;
                        pass_o  <= 1'b0;
                    end else if (tx_beat_s) begin
                        sum_tx_r <= sum_tx_r + SUM_W'(data_o);
                        lfsr_r   <= lfsr_nxt_s;
                        if (cnt_r == LAST_BEAT) begin
                            state_r <= RECV;
                            cnt_r   <= '0;
                            valid_o <= 1'b0;
                            data_o  <= '0;
                            ready_o <= 1'b1;
                        end else begin
                            cnt_r  <= cnt_r + DEPTH_LOG2'(1);
                            data_o <= lfsr_nxt_s[WIDTH-1:0];
                        end
                    end
                end
                RECV: begin
                    if (stall_abort_s) begin
                        state_r <= DONE;
                        ready_o <= 1'b0;
                        cnt_r   <= '0;
                        done_o  <= 1'b1;
                        pass_o  <= 1'b0;
                    end else if (rx_beat_s) begin
                        sum_rx_r    <= sum_rx_nxt_s;
                        err_count_o <= err_nxt_s;
                        prev_r      <= data_i;
                        if (cnt_r == LAST_BEAT) begin
                            // Verdict uses this beat's contribution so it is valid alongside done_o.
                            state_r <= DONE;
                            cnt_r   <= '0;
                            ready_o <= 1'b0;
                            done_o  <= 1'b1;
                            pass_o  <= (err_nxt_s == '0) && (sum_tx_r == sum_rx_nxt_s);
                        end else begin
                            cnt_r <= cnt_r + DEPTH_LOG2'(1);
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b0;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_batch_checker.sv
// Self-checking bench for sort_batch_checker: the bench plays the sorter and compares every cycle against a transaction-level model.
module tb_sort_batch_checker;

    localparam int          WIDTH      = 8;
    localparam int          DEPTH      = 10;
    localparam int          DEPTH_LOG2 = 4;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          ERR_MAX    = (1 << DEPTH_LOG2) - 1;

    logic                  clk = 1'b0;
    logic                  reset_ni;
    logic                  start_i;
    logic                  ready_i;
    logic                  valid_i;
    logic [WIDTH-1:0]      data_i;
    logic [WIDTH-1:0]      data_o;
    logic                  valid_o;
    logic                  ready_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  pass_o;
    logic [DEPTH_LOG2-1:0] err_count_o;
`ifdef SORT_CHECK_TIMEOUT_EN
    logic                  timeout_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sort_batch_checker #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2), .SEED(SEED)
    ) dut (
        .clk_i(clk),
        .reset_ni(reset_ni),
        .start_i(start_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .pass_o(pass_o),
`ifdef SORT_CHECK_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .err_count_o(err_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // ---------------- transaction-level model ----------------
    bit               m_active;
    bit               m_done_now;
    bit               m_pass;
    bit               m_timeout;
    int               m_sent;
    int               m_recv;
    int               m_err;
    int               m_sum_tx;
    int               m_stall;
    logic [15:0]      m_lfsr;
    logic [WIDTH-1:0] m_rx[$];

    task automatic model_finish(input bit to);
        int e;
        int srx;
        e = 0;
        srx = 0;
        foreach (m_rx[k]) begin
            srx += int'(m_rx[k]);
            if (k > 0 && m_rx[k] < m_rx[k-1]) e++;
        end
        if (e > ERR_MAX) e = ERR_MAX;
        m_err      = e;
        m_pass     = !to && (e == 0) && (srx == m_sum_tx);
        m_timeout  = to;
        m_active   = 1'b0;
        m_done_now = 1'b1;
    endtask

    always @(negedge clk) begin : compare
        bit beat;
        if (!reset_ni) begin
            check("rst_valid_o", 32'(valid_o), 32'd0);
            check("rst_ready_o", 32'(ready_o), 32'd0);
            check("rst_busy_o", 32'(busy_o), 32'd0);
            check("rst_done_o", 32'(done_o), 32'd0);
            check("rst_pass_o", 32'(pass_o), 32'd0);
            check("rst_err_count_o", 32'(err_count_o), 32'd0);
            check("rst_data_o", 32'(data_o), 32'd0);
`ifdef SORT_CHECK_TIMEOUT_EN
            check("rst_timeout_o", 32'(timeout_o), 32'd0);
`endif
            m_active = 1'b0; m_done_now = 1'b0; m_pass = 1'b0; m_timeout = 1'b0;
            m_sent = 0; m_recv = 0; m_err = 0; m_sum_tx = 0; m_stall = 0;
            m_lfsr = SEED;
            m_rx.delete();
        end else begin
            check("valid_o", 32'(valid_o), 32'(m_active && m_sent < DEPTH));
            if (m_active && m_sent < DEPTH) check("data_o", 32'(data_o), 32'(m_lfsr[WIDTH-1:0]));
            check("ready_o", 32'(ready_o), 32'(m_active && m_sent == DEPTH));
            check("busy_o", 32'(busy_o), 32'(m_active || m_done_now));
            check("done_o", 32'(done_o), 32'(m_done_now));
            check("pass_o", 32'(pass_o), 32'(m_pass));
            if (!m_active) check("err_count_o", 32'(err_count_o), 32'(m_err));
`ifdef SORT_CHECK_TIMEOUT_EN
            check("timeout_o", 32'(timeout_o), 32'(m_timeout));
`endif
            // advance the model to what the next rising edge will do
            if (m_done_now) begin
                m_done_now = 1'b0;
            end else if (!m_active) begin
                if (start_i) begin
                    m_active = 1'b1; m_pass = 1'b0; m_timeout = 1'b0;
                    m_sent = 0; m_recv = 0; m_err = 0; m_sum_tx = 0; m_stall = 0;
                    m_rx.delete();
                end
            end else begin
                beat = (m_sent < DEPTH) ? ready_i : valid_i;
                if (beat) begin
                    m_stall = 0;
                    if (m_sent < DEPTH) begin
                        m_sum_tx += int'(m_lfsr[WIDTH-1:0]);
                        m_lfsr = lfsr_next(m_lfsr);
                        m_sent++;
                    end else begin
                        m_rx.push_back(data_i);
                        m_recv++;
                        if (m_recv == DEPTH) model_finish(1'b0);
                    end
                end else begin
`ifdef SORT_CHECK_TIMEOUT_EN
                    m_stall++;
                    if (m_stall == 65535) model_finish(1'b1);
`endif
                end
            end
        end
    end

    // ---------------- stimulus: the bench acts as the sorter ----------------
    logic [WIDTH-1:0] got[$];
    logic [WIDTH-1:0] resp[$];
    int bat_lat;
    int bat_err;
    int bat_sum_tx;
    bit bat_pass;

    // mode: 0 ascending, 1 descending, 2 ascending with lowest word +1, 3 random order
    task automatic run_batch(input int mode, input bit rnd, input bit dup, input int abort_at);
        int guard;
        int t0;
        int idx;
        int j;
        int exp_err;
        int sr;
        int dcount;
        bit seen;
        logic [WIDTH-1:0] tmp;
        got.delete();
        resp.delete();
        guard = 0;
        t0 = 0;
        while (got.size() < DEPTH && guard < 400) begin
            @(posedge clk); #1;
            start_i = (guard == 0) || (dup && guard == 3);
            if (guard == 0) t0 = cyc + 1;
            ready_i = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            valid_i = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
            data_i  = WIDTH'($urandom);
            @(negedge clk);
            if (valid_o && ready_i) got.push_back(data_o);
            guard++;
            if (abort_at > 0 && got.size() == abort_at) break;
        end
        start_i = 1'b0;
        if (abort_at > 0) begin
            @(posedge clk); #1;
            reset_ni = 1'b0; ready_i = 1'b0; valid_i = 1'b0;
            repeat (3) @(negedge clk);
            @(posedge clk); #1 reset_ni = 1'b1;
            dcount = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (done_o) dcount++;
            end
            check("abort_no_done", 32'(dcount), 32'd0);
            return;
        end
        check("send_beats", 32'(got.size()), 32'(DEPTH));
        resp = got;
        if (mode == 1) resp.rsort();
        else resp.sort();
        if (mode == 2) resp[0] = resp[0] + 8'd1;
        if (mode == 3) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                j = int'($urandom_range(k, 0));
                tmp = resp[k]; resp[k] = resp[j]; resp[j] = tmp;
            end
        end
        idx = 0;
        guard = 0;
        while (idx < DEPTH && guard < 400) begin
            @(posedge clk); #1;
            ready_i = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
            valid_i = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            data_i  = valid_i ? resp[idx] : WIDTH'($urandom);
            @(negedge clk);
            if (valid_i && ready_o) idx++;
            guard++;
        end
        check("recv_beats", 32'(idx), 32'(DEPTH));
        @(posedge clk); #1;
        valid_i = 1'b0; ready_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                bat_lat  = cyc - t0 + 2;
                bat_pass = pass_o;
                bat_err  = int'(err_count_o);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        exp_err = 0; bat_sum_tx = 0; sr = 0;
        for (int k = 0; k < DEPTH; k++) begin
            bat_sum_tx += int'(got[k]);
            sr += int'(resp[k]);
            if (k > 0 && resp[k] < resp[k-1]) exp_err++;
        end
        if (exp_err > ERR_MAX) exp_err = ERR_MAX;
        check("batch_err", 32'(bat_err), 32'(exp_err));
        check("batch_pass", 32'(bat_pass), 32'((exp_err == 0) && (bat_sum_tx == sr)));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_ni = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ni = 1'b0; start_i = 1'b0; ready_i = 1'b0; valid_i = 1'b0; data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_data", 32'(data_o), 32'd0);
        @(posedge clk); #1 reset_ni = 1'b1;
        repeat (2) @(posedge clk);

        // sorted loopback from reset: pinned words, sum and latency
        run_batch(0, 1'b0, 1'b0, 0);
        check("first_word", 32'(got[0]), 32'h0000_00E1);
        check("tenth_word", 32'(got[9]), 32'h0000_00C8);
        check("batch1_sum", 32'(bat_sum_tx), 32'd1451);
        check("latency", 32'(bat_lat), 32'd22);
        check("batch1_pass", 32'(bat_pass), 32'd1);
        check("batch1_err", 32'(bat_err), 32'd0);

        // reset at send beat 5, then the sequence restarts from the seed
        run_batch(0, 1'b0, 1'b0, 5);
        run_batch(1, 1'b0, 1'b0, 0);
        check("restart_word", 32'(got[0]), 32'h0000_00E1);
        check("reverse_err", 32'(bat_err), 32'd9);
        check("reverse_pass", 32'(bat_pass), 32'd0);

        run_batch(2, 1'b0, 1'b0, 0);
        check("bumped_pass", 32'(bat_pass), 32'd0);

        // stalled send from the seed must give the same words
        pulse_reset();
        run_batch(0, 1'b1, 1'b0, 0);
        check("stall_first_word", 32'(got[0]), 32'h0000_00E1);
        check("stall_tenth_word", 32'(got[9]), 32'h0000_00C8);
        check("stall_sum", 32'(bat_sum_tx), 32'd1451);

        for (int b = 0; b < 6; b++) begin
            run_batch((b % 2 == 1) ? 3 : ((b == 2) ? 1 : 0), 1'b1, (b == 4), 0);
        end

`ifdef SORT_CHECK_TIMEOUT_EN
        begin
            bit seen_to;
            seen_to = 1'b0;
            @(posedge clk); #1 start_i = 1'b1; ready_i = 1'b1; valid_i = 1'b0;
            @(posedge clk); #1 start_i = 1'b0;
            for (int k = 0; k < 70000 && !seen_to; k++) begin
                @(negedge clk);
                if (done_o) begin
                    seen_to = 1'b1;
                    check("timeout_flag", 32'(timeout_o), 32'd1);
                    check("timeout_pass", 32'(pass_o), 32'd0);
                end
            end
            check("timeout_done_seen", 32'(seen_to), 32'd1);
            ready_i = 1'b0;
            repeat (2) @(posedge clk);
            run_batch(0, 1'b0, 1'b0, 0);
            check("timeout_cleared", 32'(timeout_o), 32'd0);
        end
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_batch_checker.md
# sort_batch_checker

Stream initiator and result checker for the byte insertion sorter. On a start pulse it pushes one batch of `DEPTH` pseudo-random words into the sorter's input handshake. It then drains `DEPTH` words from the sorter's output handshake and checks that they are non-decreasing and that their sum equals the sum of the words sent. It sits on the PC side of the sorter: the on-chip stand-in for the host and the self-test source for the sorter datapath.

## Interface
- `WIDTH`, 8: data word width (≤16)
- `DEPTH`, 10: words per batch; must equal the sorter's `DEPTH`
- `DEPTH_LOG2`, 4: counter width; `2**DEPTH_LOG2 > DEPTH`
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero
- `clk_i` in 1: single clock, rising edge
- `reset_ni` in 1: asynchronous, active-low reset
- `start_i` in 1: start one batch; sampled only in IDLE
- `data_o` out WIDTH: word to sorter input
- `valid_o` out 1: `data_o` valid
- `ready_i` in 1: sorter accepts `data_o`
- `data_i` in WIDTH: word from sorter output
- `valid_i` in 1: `data_i` valid
- `ready_o` out 1: checker accepts `data_i`
- `busy_o` out 1: state ≠ IDLE
- `done_o` out 1: one-cycle pulse at end of batch
- `pass_o` out 1: result of last batch; held until next `start_i` is accepted
- `err_count_o` out DEPTH_LOG2: ordering violations in last batch, saturating

## Operation
- States: IDLE, SEND, RECV, DONE.
- IDLE, `start_i`=1:
  - go to SEND
  - clear beat counter, sums, error count, `pass_o`
- SEND:
  - `valid_o`=1, `data_o` = `lfsr[WIDTH-1:0]`
  - on `valid_o && ready_i`: add `data_o` to `sum_tx`, step LFSR, increment counter
  - after the `DEPTH`th accepted beat: clear counter, go to RECV
- RECV:
  - `ready_o`=1
  - on `valid_i && ready_o`: add `data_i` to `sum_rx`, increment counter
  - on every beat after the first, if `data_i < prev`: increment `err_count` (saturating at all-ones)
  - register `data_i` as `prev`
  - after the `DEPTH`th beat: go to DONE
- DONE:
  - `pass_o` = (`err_count`==0) && (`sum_tx`==`sum_rx`)
  - `done_o`=1 for this cycle
  - go to IDLE
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11
  - shift left; feedback enters bit 0
  - not reseeded between batches, so consecutive batches differ
- Arithmetic:
  - sums are `WIDTH+DEPTH_LOG2` bits unsigned; no overflow at legal `DEPTH`
  - comparison is unsigned; equal neighbours are legal (duplicates)

## Timing
- Reset values:
  - state IDLE, LFSR=`SEED`
  - `valid_o`, `ready_o`, `busy_o`, `done_o`, `pass_o` = 0
  - `err_count_o`=0, `data_o`=0
- `valid_o` rises the cycle after `start_i` is sampled.
- `data_o` is stable while `valid_o && !ready_i`.
- `valid_o` never drops without a handshake.
- The SEND→RECV transition happens on the clock edge of the last accepted send beat. `ready_o` is 1 from the next cycle.
- Words presented on `valid_i` outside RECV are not accepted (`ready_o`=0).
- `done_o` is asserted the cycle after the last receive beat. `busy_o` falls the same cycle `done_o` falls.
- A `start_i` that arrives while `busy_o`=1 is ignored, not queued.
- `reset_ni` low mid-batch aborts immediately: all outputs return to reset values, and a partial batch is not reported.
- Minimum batch latency: `2*DEPTH + 2` cycles from `start_i` to `done_o`, with `ready_i` and `valid_i` held high.

## Configuration
- `SORT_CHECK_TIMEOUT_EN` defined:
  - adds a 16-bit idle counter in SEND and RECV, cleared on every handshake beat
  - at 65535 consecutive cycles without a beat: go to DONE with `pass_o` forced to 0
  - adds output `timeout_o` (1 bit): set at that abort, cleared on the next accepted `start_i`, reset value 0
- Undefined: no counter, no `timeout_o` port, and a stalled peer holds the FSM indefinitely.

## Test plan
- Reset, then `start_i` with `ready_i`=1:
  - first `data_o`=8'hE1
  - exactly 10 send beats, then `ready_o`=1
- Loopback sorted response: return the sent words in ascending order with `valid_i`=1 →
  - `done_o` pulses 22 cycles after `start_i`
  - `pass_o`=1, `err_count_o`=0
- Return the same 10 words in reverse (descending) order → `pass_o`=0, `err_count_o`=9.
- Return the ascending set with one word incremented by 1 → `err_count_o`=0, `pass_o`=0 (sum mismatch).
- `ready_i` toggled at random during SEND → `data_o` holds across stalls, and the sequence is identical to the unstalled case.
  - with `SORT_CHECK_TIMEOUT_EN`: `valid_i` held at 0 in RECV → after 65535 cycles `done_o`=1, `timeout_o`=1, `pass_o`=0.
- Pull `reset_ni` low at send beat 5, release, then `start_i` → batch restarts from `data_o`=8'hE1, and no `done_o` is emitted for the aborted batch.
